// File: rtl/int_rs_storage.sv
// Integer reservation-station entry array: dispatch into the lowest free entry, CDB wakeup,
// per-entry issue requests, 0-latency payload reads for the issue slots, and occupancy count.
module int_rs_storage #(
  parameter int unsigned INTRS_DEPTH     = 8,
  parameter int unsigned INTRS_IDX       = 3,
  parameter int unsigned INT_ISSUE_WIDTH = 2,
  parameter int unsigned CDB_WIDTH       = 2,
  parameter int unsigned PRF_IDX         = 6,
  parameter int unsigned ROB_IDX         = 5,
  parameter int unsigned UOP_W           = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       dispatch_valid,
  output logic                       dispatch_ready,
  input  logic [UOP_W-1:0]           dispatch_uop,
  input  logic [PRF_IDX-1:0]         dispatch_rs1_phy,
  input  logic [PRF_IDX-1:0]         dispatch_rs2_phy,
  input  logic                       dispatch_rs1_rdy,
  input  logic                       dispatch_rs2_rdy,
  input  logic [PRF_IDX-1:0]         dispatch_rd_phy,
  input  logic [ROB_IDX-1:0]         dispatch_rob_id,
  input  logic [CDB_WIDTH-1:0]       cdb_valid,
  input  logic [PRF_IDX-1:0]         cdb_rd_phy    [CDB_WIDTH],
  output logic [INTRS_DEPTH-1:0]     rs_request,
  input  logic [INTRS_DEPTH-1:0]     rs_grant,
  input  logic [INT_ISSUE_WIDTH-1:0] fu_issue_en,
  input  logic [INTRS_IDX-1:0]       fu_issue_idx  [INT_ISSUE_WIDTH],
  output logic [UOP_W-1:0]           issue_uop     [INT_ISSUE_WIDTH],
  output logic [PRF_IDX-1:0]         issue_rs1_phy [INT_ISSUE_WIDTH],
  output logic [PRF_IDX-1:0]         issue_rs2_phy [INT_ISSUE_WIDTH],
  output logic [PRF_IDX-1:0]         issue_rd_phy  [INT_ISSUE_WIDTH],
  output logic [ROB_IDX-1:0]         issue_rob_id  [INT_ISSUE_WIDTH],
  output logic [INTRS_IDX:0]         rs_count
);

  logic [INTRS_DEPTH-1:0] valid_q, valid_d;
  logic [INTRS_DEPTH-1:0] rs1_rdy_q, rs1_rdy_d;
  logic [INTRS_DEPTH-1:0] rs2_rdy_q, rs2_rdy_d;
  logic [INTRS_IDX:0]     count_q, count_d;

  logic [UOP_W-1:0]   uop_q [INTRS_DEPTH];
  logic [PRF_IDX-1:0] rs1_q [INTRS_DEPTH];
  logic [PRF_IDX-1:0] rs2_q [INTRS_DEPTH];
  logic [PRF_IDX-1:0] rd_q  [INTRS_DEPTH];
  logic [ROB_IDX-1:0] rob_q [INTRS_DEPTH];

  logic [INTRS_IDX-1:0]   free_idx;
  logic [INTRS_DEPTH-1:0] hit1, hit2;
  logic                   disp_hit1, disp_hit2;
  logic                   accept;
  logic [INTRS_IDX:0]     grant_cnt;

  // Readiness looks only at registered occupancy, so a same-cycle grant never frees a slot.
  assign dispatch_ready = rst_n & ~(&valid_q);
  assign rs_request     = valid_q & rs1_rdy_q & rs2_rdy_q & {INTRS_DEPTH{rst_n}};
  assign accept         = dispatch_valid & dispatch_ready & ~flush;
  assign grant_cnt      = (INTRS_IDX + 1)'($countones(rs_grant & valid_q));
  assign rs_count       = count_q;

  always_comb begin
    free_idx = '0;
    for (int i = INTRS_DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = INTRS_IDX'(i);
    end
  end

  always_comb begin
    hit1      = '0;
    hit2      = '0;
    disp_hit1 = 1'b0;
    disp_hit2 = 1'b0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (cdb_valid[k]) begin
        for (int i = 0; i < INTRS_DEPTH; i++) begin
          if (rs1_q[i] == cdb_rd_phy[k]) hit1[i] = 1'b1;
          if (rs2_q[i] == cdb_rd_phy[k]) hit2[i] = 1'b1;
        end
        if (dispatch_rs1_phy == cdb_rd_phy[k]) disp_hit1 = 1'b1;
        if (dispatch_rs2_phy == cdb_rd_phy[k]) disp_hit2 = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d   = valid_q & ~rs_grant;
    rs1_rdy_d = rs1_rdy_q | hit1;
    rs2_rdy_d = rs2_rdy_q | hit2;
    count_d   = count_q + {{INTRS_IDX{1'b0}}, accept} - grant_cnt;
    if (accept) begin
      valid_d[free_idx]   = 1'b1;
      rs1_rdy_d[free_idx] = dispatch_rs1_rdy | disp_hit1;
      rs2_rdy_d[free_idx] = dispatch_rs2_rdy | disp_hit2;
    end
    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      count_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      rs1_rdy_q <= rs1_rdy_d;
      rs2_rdy_q <= rs2_rdy_d;
      count_q   <= count_d;
    end
  end

  // Payload storage needs no reset: it is only observed while the entry is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      uop_q[free_idx] <= dispatch_uop;
      rs1_q[free_idx] <= dispatch_rs1_phy;
      rs2_q[free_idx] <= dispatch_rs2_phy;
      rd_q[free_idx]  <= dispatch_rd_phy;
      rob_q[free_idx] <= dispatch_rob_id;
    end
  end

  always_comb begin
    for (int s = 0; s < INT_ISSUE_WIDTH; s++) begin
      issue_uop[s]     = '0;
      issue_rs1_phy[s] = '0;
      issue_rs2_phy[s] = '0;
      issue_rd_phy[s]  = '0;
      issue_rob_id[s]  = '0;
      if (fu_issue_en[s]) begin
        issue_uop[s]     = uop_q[fu_issue_idx[s]];
        issue_rs1_phy[s] = rs1_q[fu_issue_idx[s]];
        issue_rs2_phy[s] = rs2_q[fu_issue_idx[s]];
        issue_rd_phy[s]  = rd_q[fu_issue_idx[s]];
        issue_rob_id[s]  = rob_q[fu_issue_idx[s]];
      end
    end
  end

endmodule

// File: tb/tb_int_rs_storage.sv
// Bench for int_rs_storage: directed scenarios with literal expectations, then random traffic
// checked every cycle against an entry-list model of the reservation station.
`define CHK(n, a, e) begin n_checks++; if ((64'(a)) !== (64'(e))) begin n_fail++; $display("FAIL %s: got %0h expected %0h at %0t", n, 64'(a), 64'(e), $time); end end

module tb_int_rs_storage;
  localparam int D  = 8;
  localparam int IW = 2;
  localparam int CW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        dispatch_valid = 1'b0;
  logic        dispatch_ready;
  logic [31:0] dispatch_uop = '0;
  logic [5:0]  dispatch_rs1_phy = '0, dispatch_rs2_phy = '0, dispatch_rd_phy = '0;
  logic        dispatch_rs1_rdy = 1'b0, dispatch_rs2_rdy = 1'b0;
  logic [4:0]  dispatch_rob_id = '0;
  logic [CW-1:0] cdb_valid = '0;
  logic [5:0]  cdb_rd_phy [CW];
  logic [D-1:0] rs_request;
  logic [D-1:0] rs_grant = '0;
  logic [IW-1:0] fu_issue_en = '0;
  logic [2:0]  fu_issue_idx [IW];
  logic [31:0] issue_uop [IW];
  logic [5:0]  issue_rs1_phy [IW], issue_rs2_phy [IW], issue_rd_phy [IW];
  logic [4:0]  issue_rob_id [IW];
  logic [3:0]  rs_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  int_rs_storage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .dispatch_valid   (dispatch_valid),
    .dispatch_ready   (dispatch_ready),
    .dispatch_uop     (dispatch_uop),
    .dispatch_rs1_phy (dispatch_rs1_phy),
    .dispatch_rs2_phy (dispatch_rs2_phy),
    .dispatch_rs1_rdy (dispatch_rs1_rdy),
    .dispatch_rs2_rdy (dispatch_rs2_rdy),
    .dispatch_rd_phy  (dispatch_rd_phy),
    .dispatch_rob_id  (dispatch_rob_id),
    .cdb_valid        (cdb_valid),
    .cdb_rd_phy       (cdb_rd_phy),
    .rs_request       (rs_request),
    .rs_grant         (rs_grant),
    .fu_issue_en      (fu_issue_en),
    .fu_issue_idx     (fu_issue_idx),
    .issue_uop        (issue_uop),
    .issue_rs1_phy    (issue_rs1_phy),
    .issue_rs2_phy    (issue_rs2_phy),
    .issue_rd_phy     (issue_rd_phy),
    .issue_rob_id     (issue_rob_id),
    .rs_count         (rs_count)
  );

  // Model: a plain list of entries, each with its own readiness flags and payload.
  typedef struct {
    bit         v;
    bit         r1;
    bit         r2;
    logic [5:0] t1;
    logic [5:0] t2;
    logic [5:0] rd;
    logic [4:0] rob;
    logic [31:0] uop;
  } ent_t;
  ent_t m [D];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cdb_hit(input logic [5:0] t);
    for (int k = 0; k < CW; k++) if (cdb_valid[k] && cdb_rd_phy[k] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < D; i++) if (m[i].v) c++;
    return c;
  endfunction

  function automatic logic [D-1:0] m_req();
    logic [D-1:0] r = '0;
    for (int i = 0; i < D; i++) r[i] = rst_n && m[i].v && m[i].r1 && m[i].r2;
    return r;
  endfunction

  function automatic bit m_ready();
    return rst_n && (m_count() < D);
  endfunction

  task automatic compare_model();
    logic [D-1:0] exp_req;
    if (!chk_en) return;
    exp_req = m_req();
    for (int i = 0; i < D; i++) begin
      n_checks++;
      if (rs_request[i] !== exp_req[i]) begin
        n_fail++;
        $display("FAIL rs_request[%0d]: got %b expected %b at %0t", i, rs_request[i],
                 exp_req[i], $time);
      end
    end
    n_checks++;
    if (dispatch_ready !== m_ready()) begin
      n_fail++;
      $display("FAIL dispatch_ready: got %b expected %b at %0t", dispatch_ready, m_ready(),
               $time);
    end
    n_checks++;
    if (int'(rs_count) != m_count()) begin
      n_fail++;
      $display("FAIL rs_count: got %0d expected %0d at %0t", rs_count, m_count(), $time);
    end
    for (int s = 0; s < IW; s++) begin
      if (fu_issue_en[s] && m[fu_issue_idx[s]].v) begin
        `CHK("issue_uop", issue_uop[s], m[fu_issue_idx[s]].uop);
        `CHK("issue_rs1_phy", issue_rs1_phy[s], m[fu_issue_idx[s]].t1);
        `CHK("issue_rs2_phy", issue_rs2_phy[s], m[fu_issue_idx[s]].t2);
        `CHK("issue_rd_phy", issue_rd_phy[s], m[fu_issue_idx[s]].rd);
        `CHK("issue_rob_id", issue_rob_id[s], m[fu_issue_idx[s]].rob);
      end
    end
  endtask

  task automatic model_step();
    bit acc;
    int slot;
    if (!rst_n) begin
      for (int i = 0; i < D; i++) m[i].v = 1'b0;
      chk_en = 1'b1;
    end else if (flush) begin
      for (int i = 0; i < D; i++) m[i].v = 1'b0;
    end else begin
      acc  = dispatch_valid && m_ready();
      slot = -1;
      for (int i = 0; i < D; i++) if (!m[i].v && slot < 0) slot = i;
      for (int i = 0; i < D; i++) begin
        if (rs_grant[i]) m[i].v = 1'b0;
        if (cdb_hit(m[i].t1)) m[i].r1 = 1'b1;
        if (cdb_hit(m[i].t2)) m[i].r2 = 1'b1;
      end
      if (acc) begin
        m[slot].v   = 1'b1;
        m[slot].r1  = dispatch_rs1_rdy || cdb_hit(dispatch_rs1_phy);
        m[slot].r2  = dispatch_rs2_rdy || cdb_hit(dispatch_rs2_phy);
        m[slot].t1  = dispatch_rs1_phy;
        m[slot].t2  = dispatch_rs2_phy;
        m[slot].rd  = dispatch_rd_phy;
        m[slot].rob = dispatch_rob_id;
        m[slot].uop = dispatch_uop;
      end
    end
  endtask

  // One clock: compare mid-cycle, advance the model at the edge, return just after it.
  task automatic cyc();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    cdb_valid      = '0;
    rs_grant       = '0;
    fu_issue_en    = '0;
    flush          = 1'b0;
  endtask

  task automatic disp(input logic [31:0] u, input logic [5:0] a, input bit ar,
                      input logic [5:0] b, input bit br, input logic [5:0] d,
                      input logic [4:0] rob);
    dispatch_valid   = 1'b1;
    dispatch_uop     = u;
    dispatch_rs1_phy = a;
    dispatch_rs1_rdy = ar;
    dispatch_rs2_phy = b;
    dispatch_rs2_rdy = br;
    dispatch_rd_phy  = d;
    dispatch_rob_id  = rob;
  endtask

  initial begin
    cdb_rd_phy[0]   = '0;
    cdb_rd_phy[1]   = '0;
    fu_issue_idx[0] = '0;
    fu_issue_idx[1] = '0;
    for (int i = 0; i < D; i++) m[i].v = 1'b0;

    idle();
    rst_n = 1'b0;
    repeat (2) cyc();
    `CHK("reset_ready", dispatch_ready, 1'b0);
    `CHK("reset_req", rs_request, 8'h00);
    `CHK("reset_count", rs_count, 4'd0);
    n_checks++;
    if (dispatch_ready !== 1'b0 || rs_request !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs at %0t", $time);
    end
    rst_n = 1'b1;
    #1;
    `CHK("ready_after_reset", dispatch_ready, 1'b1);

    // Single ready dispatch lands in entry 0.
    disp(32'h1111, 6'd1, 1'b1, 6'd2, 1'b1, 6'd10, 5'd1);
    cyc(); idle();
    `CHK("t1_req", rs_request, 8'h01);
    `CHK("t1_count", rs_count, 4'd1);
    n_checks++;
    if (rs_request !== 8'h01) begin
      n_fail++;
      $display("FAIL t1_req_inline: got %0h at %0t", rs_request, $time);
    end

    // Same-cycle CDB bypass at dispatch.
    disp(32'h2222, 6'd5, 1'b0, 6'd7, 1'b1, 6'd11, 5'd2);
    cdb_valid = 2'b01; cdb_rd_phy[0] = 6'd5;
    cyc(); idle();
    `CHK("t2_bypass_req", rs_request, 8'h03);

    // Stored operand woken in cycle N requests at N+1.
    disp(32'h3333, 6'd3, 1'b1, 6'd9, 1'b0, 6'd12, 5'd3);
    cyc(); idle();
    `CHK("t2_pending_req", rs_request, 8'h03);
    cdb_valid = 2'b10; cdb_rd_phy[1] = 6'd9;
    #1;
    `CHK("t2_wake_same_cycle", rs_request, 8'h03);
    cyc(); idle();
    `CHK("t2_wake_next_cycle", rs_request, 8'h07);
    `CHK("t2_count", rs_count, 4'd3);

    // Fill, then grant 2 and 5 while a dispatch is held.
    for (int i = 3; i < D; i++) begin
      disp(32'h4000 + 32'(i), 6'(i), 1'b1, 6'(i + 20), 1'b1, 6'(i), 5'(10 + i));
      cyc();
    end
    idle();
    `CHK("t3_full_ready", dispatch_ready, 1'b0);
    `CHK("t3_full_count", rs_count, 4'd8);
    `CHK("t3_full_req", rs_request, 8'hFF);
    disp(32'h5555, 6'd1, 1'b1, 6'd2, 1'b1, 6'd30, 5'd20);
    rs_grant = 8'h24; fu_issue_en = 2'b11; fu_issue_idx[0] = 3'd2; fu_issue_idx[1] = 3'd5;
    cyc();
    rs_grant = '0; fu_issue_en = '0;
    `CHK("t3_after_grant_count", rs_count, 4'd6);
    `CHK("t3_after_grant_ready", dispatch_ready, 1'b1);
    cyc(); idle();
    `CHK("t3_land_count", rs_count, 4'd7);
    `CHK("t3_land_req", rs_request, 8'hDF);
    fu_issue_en = 2'b01; fu_issue_idx[0] = 3'd2;
    #1;
    `CHK("t3_land_entry2_rob", issue_rob_id[0], 5'd20);
    fu_issue_en = '0;

    // Two-slot issue read and grant.
    fu_issue_idx[0] = 3'd3; fu_issue_idx[1] = 3'd6; fu_issue_en = 2'b11; rs_grant = 8'h48;
    #1;
    `CHK("t4_slot0_rob", issue_rob_id[0], 5'd13);
    `CHK("t4_slot1_rob", issue_rob_id[1], 5'd16);
    `CHK("t4_slot1_uop", issue_uop[1], 32'h4006);
    n_checks++;
    if (issue_rob_id[0] !== 5'd13 || issue_rob_id[1] !== 5'd16) begin
      n_fail++;
      $display("FAIL t4_rob_inline: %0d %0d at %0t", issue_rob_id[0], issue_rob_id[1], $time);
    end
    cyc(); idle();
    `CHK("t4_req", rs_request, 8'h97);
    `CHK("t4_count", rs_count, 4'd5);

    // Flush with 4 valid entries plus a simultaneous dispatch and grant.
    rs_grant = 8'h01;
    cyc(); idle();
    `CHK("t5_pre_count", rs_count, 4'd4);
    flush = 1'b1; rs_grant = 8'h02;
    disp(32'h6666, 6'd1, 1'b1, 6'd1, 1'b1, 6'd1, 5'd1);
    cyc(); idle();
    `CHK("t5_req", rs_request, 8'h00);
    `CHK("t5_count", rs_count, 4'd0);
    `CHK("t5_ready", dispatch_ready, 1'b1);

    // Reset mid-operation with 5 entries pending.
    for (int i = 0; i < 5; i++) begin
      disp(32'h7000 + 32'(i), 6'(i), 1'b1, 6'(i), 1'b1, 6'(i), 5'(i));
      cyc();
    end
    idle();
    `CHK("t6_pre_count", rs_count, 4'd5);
    rst_n = 1'b0;
    disp(32'h7777, 6'd1, 1'b1, 6'd1, 1'b1, 6'd1, 5'd1);
    #1;
    `CHK("t6_rst_req", rs_request, 8'h00);
    `CHK("t6_rst_ready", dispatch_ready, 1'b0);
    cyc(); cyc();
    `CHK("t6_rst_req_held", rs_request, 8'h00);
    rst_n = 1'b1;
    idle();
    #1;
    `CHK("t6_rel_count", rs_count, 4'd0);
    `CHK("t6_rel_req", rs_request, 8'h00);
    repeat (3) begin
      cyc();
      `CHK("t6_no_stale_req", rs_request, 8'h00);
    end

    // Random traffic; alternate phases let the array drain and fill.
    for (int n = 0; n < 4000; n++) begin
      logic [D-1:0] req;
      bit           fill_phase;
      idle();
      fill_phase       = ((n / 150) % 2) == 1;
      rst_n            = ($urandom_range(0, 299) != 0);
      flush            = ($urandom_range(0, 79) == 0);
      dispatch_valid   = ($urandom_range(0, 9) < 6);
      dispatch_uop     = $urandom();
      dispatch_rs1_phy = 6'($urandom_range(0, 15));
      dispatch_rs2_phy = 6'($urandom_range(0, 15));
      dispatch_rs1_rdy = ($urandom_range(0, 2) == 0);
      dispatch_rs2_rdy = ($urandom_range(0, 2) == 0);
      dispatch_rd_phy  = 6'($urandom_range(0, 63));
      dispatch_rob_id  = 5'($urandom_range(0, 31));
      cdb_valid        = 2'($urandom_range(0, 3));
      for (int k = 0; k < CW; k++) cdb_rd_phy[k] = 6'($urandom_range(0, 15));
      req = m_req();
      for (int s = 0; s < IW; s++) begin
        int p;
        p = $urandom_range(0, D - 1);
        if (req[p] && !rs_grant[p] && ($urandom_range(0, 3) < (fill_phase ? 1 : 3))) begin
          rs_grant[p]     = 1'b1;
          fu_issue_en[s]  = 1'b1;
          fu_issue_idx[s] = 3'(p);
        end
      end
      cyc();
    end
    idle();
    rst_n = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
